// File: rtl/spi_master_if.sv
`default_nettype none
// ============================================================================
// spi_master_if : host control port and SPI bus signals of spi_master
// Rev 1.0
// ============================================================================
interface spi_master_if #(
  parameter int NUM_SLAVES = 2,
  parameter int SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
);
  logic                  start_i;
  logic [SEL_W-1:0]      slave_sel_i;
  logic [7:0]            tx_data_i;
  logic                  busy_o;
  logic                  done_o;
  logic [7:0]            rx_data_o;
  logic                  sck_o;
  logic                  mosi_o;
  logic                  miso_i;
  logic [NUM_SLAVES-1:0] ss_o;

  modport master (
    input  start_i, slave_sel_i, tx_data_i, miso_i,
    output busy_o, done_o, rx_data_o, sck_o, mosi_o, ss_o
  );

  modport slave (
    output start_i, slave_sel_i, tx_data_i, miso_i,
    input  busy_o, done_o, rx_data_o, sck_o, mosi_o, ss_o
  );
endinterface
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// ============================================================================
// spi_master : single-byte SPI mode-0 master with one-hot active-high selects
// Rev 1.0
// ============================================================================
module spi_master #(
  parameter int NUM_SLAVES = 2,
  parameter int CLK_DIV    = 4,
  parameter int HOLD_CYC   = 4,
  parameter int SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic         Clk_i,
  input  logic         Rst_i,
  spi_master_if.master bus
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_LEAD  = 3'd1;
  localparam logic [2:0] c_HIGH  = 3'd2;
  localparam logic [2:0] c_LOW   = 3'd3;
  localparam logic [2:0] c_TRAIL = 3'd4;
  localparam logic [2:0] c_GAP   = 3'd5;

  // One counter serves both the SCK half-periods and the SS hold time.
  localparam int                c_CNT_MAX   = (CLK_DIV > HOLD_CYC) ? CLK_DIV : HOLD_CYC;
  localparam int                c_HC_W      = $clog2(c_CNT_MAX);
  localparam logic [c_HC_W-1:0] c_DIV_LAST  = c_HC_W'(CLK_DIV - 1);
  localparam logic [c_HC_W-1:0] c_HOLD_LAST = c_HC_W'(HOLD_CYC - 1);
  localparam logic [SEL_W:0]    c_NUM_SEL   = (SEL_W + 1)'(NUM_SLAVES);

  logic [2:0]            r_state;
  logic [c_HC_W-1:0]     r_hc;
  logic [2:0]            r_bc;
  logic [7:0]            r_tx;
  logic [7:0]            r_rx;
  logic [7:0]            r_rx_data;
  logic [NUM_SLAVES-1:0] r_ss;
  logic                  r_done;

  logic                  w_sel_ok;
  logic                  w_div_last;
  logic                  w_hold_last;
  logic [NUM_SLAVES-1:0] w_ss_dec;

  assign w_sel_ok    = ({1'b0, bus.slave_sel_i} < c_NUM_SEL);
  assign w_div_last  = (r_hc == c_DIV_LAST);
  assign w_hold_last = (r_hc == c_HOLD_LAST);
  assign w_ss_dec    = NUM_SLAVES'(1) << bus.slave_sel_i;

  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      r_state   <= c_IDLE;
      r_hc      <= '0;
      r_bc      <= '0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_rx_data <= '0;
      r_ss      <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          r_hc <= '0;
          r_bc <= '0;
          if (bus.start_i && w_sel_ok) begin
            r_state <= c_LEAD;
            r_ss    <= w_ss_dec;
            r_tx    <= bus.tx_data_i;
          end
        end
        c_LEAD: begin
          if (w_div_last) begin
            r_hc    <= '0;
            r_state <= c_HIGH;
            r_rx    <= {r_rx[6:0], bus.miso_i};
          end else begin
            r_hc <= r_hc + 1'b1;
          end
        end
        c_HIGH: begin
          if (w_div_last) begin
            r_hc <= '0;
            if (r_bc == 3'd7) begin
              r_state <= c_TRAIL;
            end else begin
              r_state <= c_LOW;
              r_bc    <= r_bc + 3'd1;
              r_tx    <= {r_tx[6:0], 1'b0};
            end
          end else begin
            r_hc <= r_hc + 1'b1;
          end
        end
        c_LOW: begin
          if (w_div_last) begin
            r_hc    <= '0;
            r_state <= c_HIGH;
            r_rx    <= {r_rx[6:0], bus.miso_i};
          end else begin
            r_hc <= r_hc + 1'b1;
          end
        end
        c_TRAIL: begin
          if (w_hold_last) begin
            r_hc      <= '0;
            r_state   <= c_GAP;
            r_ss      <= '0;
            r_done    <= 1'b1;
            r_rx_data <= r_rx;
          end else begin
            r_hc <= r_hc + 1'b1;
          end
        end
        c_GAP: begin
          if (w_div_last) begin
            r_hc    <= '0;
            r_state <= c_IDLE;
          end else begin
            r_hc <= r_hc + 1'b1;
          end
        end
        default: begin
          r_state <= c_IDLE;
          r_hc    <= '0;
          r_ss    <= '0;
        end
      endcase
    end
  end

  // SCK and busy follow the state register directly, so they reset instantly.
  assign bus.sck_o     = (r_state == c_HIGH);
  assign bus.busy_o    = (r_state != c_IDLE);
  assign bus.mosi_o    = r_tx[7];
  assign bus.ss_o      = r_ss;
  assign bus.done_o    = r_done;
  assign bus.rx_data_o = r_rx_data;

endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// ============================================================================
// tb_spi_master : random + directed bench with reference model and scoreboard
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_spi_master;
  localparam int NS       = 2;
  localparam int SW       = 2;
  localparam int CD       = 4;
  localparam int HC       = 4;
  localparam int BUSY_LEN = 17*CD + HC;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] miso;
    int         sel;
  } xfer_t;

  logic Clk_i = 1'b0;
  logic Rst_i = 1'b1;
  always #5 Clk_i = ~Clk_i;

  spi_master_if #(.NUM_SLAVES(NS), .SEL_W(SW)) bus();

  spi_master #(.NUM_SLAVES(NS), .CLK_DIV(CD), .HOLD_CYC(HC), .SEL_W(SW)) dut (
    .Clk_i (Clk_i),
    .Rst_i (Rst_i),
    .bus   (bus.master)
  );

  int         errors = 0;
  int         checks = 0;
  xfer_t      q_done[$];
  xfer_t      q_slave[$];
  logic [7:0] cur_miso = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  // Reference model: remaining busy cycles of the transfer in flight.
  int    m_cnt = 0;
  xfer_t m_cur;
  always @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      m_cnt = 0;
      q_done.delete();
      q_slave.delete();
    end else if (m_cnt > 0) begin
      m_cnt--;
    end else if (bus.start_i && int'(bus.slave_sel_i) < NS) begin
      m_cur.tx   = bus.tx_data_i;
      m_cur.miso = cur_miso;
      m_cur.sel  = int'(bus.slave_sel_i);
      q_done.push_back(m_cur);
      q_slave.push_back(m_cur);
      m_cnt = BUSY_LEN;
    end
  end

  // Per-cycle comparison of the bus against the model's timeline (k = busy cycle 1..BUSY_LEN).
  int k, h;
  always @(negedge Clk_i) begin
    if (!Rst_i) begin
      k = BUSY_LEN + 1 - m_cnt;
      h = (k - 1) / CD;
      chk("busy", bus.busy_o, m_cnt != 0);
      chk("done", bus.done_o, m_cnt == CD);
      chk("ss", bus.ss_o, (m_cnt > CD) ? (1 << m_cur.sel) : 0);
      chk("sck", bus.sck_o, (m_cnt != 0 && k <= 16*CD) ? (h % 2) : 0);
      if (m_cnt > CD)
        chk("mosi", bus.mosi_o, m_cur.tx[7 - ((h > 15 ? 15 : h) / 2)]);
    end
  end

  // Scoreboard monitor: one expected byte per done pulse.
  xfer_t sb_item;
  always @(negedge Clk_i) begin
    if (!Rst_i && bus.done_o) begin
      if (q_done.size() == 0) begin
        timeout("done_unexpected");
      end else begin
        sb_item = q_done.pop_front();
        chk("rx_data", bus.rx_data_o, sb_item.miso);
      end
    end
  end

  // Mode-0 slave model: MISO shifts on SCK fall, MOSI captured on SCK rise.
  logic          p_sck = 1'b0, p_mosi = 1'b0;
  logic [NS-1:0] p_ss = '0;
  bit            s_act = 1'b0;
  int            s_rises = 0, s_hi = 0, s_low = 1000;
  logic [7:0]    s_rx = '0, s_shift = '0;
  xfer_t         s_cur;
  initial bus.miso_i = 1'b0;
  always @(negedge Clk_i) begin
    if (Rst_i) begin
      s_act = 1'b0; s_low = 1000; bus.miso_i = 1'b0;
      p_sck = 1'b0; p_ss = '0; p_mosi = 1'b0;
    end else begin
      if (p_ss == 0 && bus.ss_o != 0) begin
        chk("ss_low_gap_ok", s_low >= CD, 1'b1);
        if (q_slave.size() == 0) begin
          timeout("ss_unexpected");
        end else begin
          s_cur = q_slave.pop_front();
          s_act = 1'b1; s_shift = s_cur.miso; bus.miso_i = s_shift[7];
          s_rises = 0; s_rx = '0;
        end
      end
      if (s_act) begin
        if (bus.sck_o && !p_sck) begin
          s_rx = {s_rx[6:0], bus.mosi_o}; s_rises++; s_hi = 0;
        end
        if (bus.sck_o) s_hi++;
        if (!bus.sck_o && p_sck) begin
          chk("sck_high_width", s_hi, CD);
          s_shift = {s_shift[6:0], 1'b0}; bus.miso_i = s_shift[7];
        end
      end
      if (p_ss != 0 && bus.ss_o == 0 && s_act) begin
        chk("slave_rcvd", s_rx, s_cur.tx);
        chk("sck_rises", s_rises, 8);
        s_act = 1'b0; s_low = 0;
      end
      if (bus.ss_o == 0) s_low++;
      if (bus.mosi_o !== p_mosi) chk("mosi_chg_sck_low", bus.sck_o, 1'b0);
      if (bus.ss_o !== p_ss) chk("ss_chg_sck_low", {p_sck, bus.sck_o}, 2'b00);
      p_sck = bus.sck_o; p_ss = bus.ss_o; p_mosi = bus.mosi_o;
    end
  end

  task automatic issue(input int sel, input logic [7:0] tx, input logic [7:0] mi, input int len);
    @(negedge Clk_i);
    bus.start_i = 1'b1; bus.slave_sel_i = SW'(sel); bus.tx_data_i = tx; cur_miso = mi;
    repeat (len) @(negedge Clk_i);
    bus.start_i = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk_i);
      if (!bus.busy_o && m_cnt == 0) return;
    end
    timeout("wait_idle");
  endtask

  task automatic wait_busy(input logic lvl);
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk_i);
      if (bus.busy_o == lvl) return;
    end
    timeout("wait_busy");
  endtask

  initial begin
    bus.start_i = 1'b0; bus.slave_sel_i = '0; bus.tx_data_i = '0;
    Rst_i = 1'b1;
    repeat (3) @(negedge Clk_i);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_done", bus.done_o, 1'b0);
    chk("rst_rx", bus.rx_data_o, 8'h00);
    chk("rst_sck", bus.sck_o, 1'b0);
    chk("rst_mosi", bus.mosi_o, 1'b0);
    chk("rst_ss", bus.ss_o, 2'b00);
    Rst_i = 1'b0;

    // Directed transfer with ignored starts mid-HIGH and on the done cycle.
    issue(0, 8'hA5, 8'h3C, 1);
    begin : mid_high
      for (int i = 0; i < 200; i++) begin
        @(negedge Clk_i);
        if (bus.sck_o) disable mid_high;
      end
      timeout("wait_sck_high");
    end
    bus.start_i = 1'b1; bus.slave_sel_i = 2'd1; bus.tx_data_i = 8'h55;
    @(negedge Clk_i);
    bus.start_i = 1'b0;
    begin : on_done
      for (int i = 0; i < 200; i++) begin
        if (bus.done_o) disable on_done;
        @(negedge Clk_i);
      end
      timeout("wait_done");
    end
    bus.start_i = 1'b1; bus.slave_sel_i = 2'd0;
    @(negedge Clk_i);
    bus.start_i = 1'b0;
    wait_idle();
    chk("rx_held", bus.rx_data_o, 8'h3C);

    // Back-to-back with start held high.
    @(negedge Clk_i);
    bus.start_i = 1'b1; bus.slave_sel_i = 2'd1; bus.tx_data_i = 8'h00; cur_miso = 8'hC3;
    wait_busy(1'b1);
    bus.slave_sel_i = 2'd0; bus.tx_data_i = 8'hFF; cur_miso = 8'h5A;
    wait_busy(1'b0);
    wait_busy(1'b1);
    bus.start_i = 1'b0;
    wait_idle();

    // Out-of-range select is ignored.
    issue(2, 8'h96, 8'h11, 3);
    repeat (20) @(negedge Clk_i);

    // Reset during bit 4, then a clean transfer.
    issue(1, 8'h6B, 8'hE7, 1);
    begin : bit4
      for (int i = 0; i < 200; i++) begin
        @(negedge Clk_i);
        if (s_act && s_rises >= 5) disable bit4;
      end
      timeout("wait_bit4");
    end
    #1 Rst_i = 1'b1;
    #1;
    chk("midrst_sck", bus.sck_o, 1'b0);
    chk("midrst_ss", bus.ss_o, 2'b00);
    chk("midrst_busy", bus.busy_o, 1'b0);
    chk("midrst_rx", bus.rx_data_o, 8'h00);
    chk("midrst_done", bus.done_o, 1'b0);
    @(negedge Clk_i);
    @(negedge Clk_i);
    Rst_i = 1'b0;
    issue(1, 8'h3D, 8'h9E, 1);
    wait_idle();
    chk("post_rst_rx", bus.rx_data_o, 8'h9E);

    // Randomised traffic, including invalid selects and starts while busy.
    for (int n = 0; n < 10; n++) begin
      issue($urandom_range(0, 2), 8'($urandom), 8'($urandom), $urandom_range(1, 3));
      repeat ($urandom_range(1, 100)) @(negedge Clk_i);
    end
    wait_idle();
    repeat (2) @(negedge Clk_i);
    chk("sb_empty", q_done.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
`default_nettype wire
